dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters: the core load/store path (port C) and an auxiliary master (port X), e.g. a debug/DMA loader.
- Fixed priority to the core, with a starvation counter that promotes X.
- Registers the winning request onto the memory pins and tracks in-flight reads, so read data is returned to the correct requester.
- Sits between the core's memory path and the data memory instance, replacing the direct connection.

Parameters:
- ADDR_W, 10, word-address width of the data memory.
- DATA_W, 32, data width.
- RD_LAT, 1, cycles from mem_address being driven until mem_q is valid (legal: 1 or 2).
- STARVE_LIM, 4, consecutive denied cycles of x_req before X takes priority (legal: 1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- c_req  in  1  core access request; held with c_we/c_addr/c_wdata stable until c_gnt.
- c_we  in  1  1 = write, 0 = read.
- c_addr  in  ADDR_W  core word address.
- c_wdata  in  DATA_W  core write data.
- c_gnt  out  1  combinational; request accepted this cycle.
- c_rvalid  out  1  one-cycle pulse; c_rdata valid.
- c_rdata  out  DATA_W  read data for the core.
- x_req, x_we, x_addr, x_wdata, x_gnt, x_rvalid, x_rdata: same as the core port, for the auxiliary master.
- x_err  out  1  one-cycle pulse, aux write rejected (optional feature only).
- mem_address  out  ADDR_W  registered address to the data memory.
- mem_data  out  DATA_W  registered write data.
- mem_wren  out  1  registered write enable.
- mem_q  in  DATA_W  memory read data.

Behaviour:
- Reset (async, rst_n=0): mem_address=0, mem_data=0, mem_wren=0, starve_cnt=0, pending-read pipe cleared, all rvalid=0, x_err=0. c_gnt and x_gnt are 0 while rst_n=0.
- Handshake: a transfer occurs in a cycle where req=1 and gnt=1. Requesters may present a new request the next cycle, so back-to-back transfers are allowed.
- Arbitration (combinational, same cycle):
  - If starve_cnt >= STARVE_LIM and x_req=1: x wins.
  - Else if c_req=1: c wins.
  - Else if x_req=1: x wins.
  - At most one gnt is high in any cycle.
- Issue: at the edge ending the grant cycle N, mem_address/mem_data/mem_wren load from the winner. mem_wren=1 only for a granted write and is high for exactly cycle N+1. In cycles with no grant, mem_wren=0 and mem_address/mem_data hold their values.
- Read return:
  - Each granted read pushes tag {valid, port} into an RD_LAT+1 deep shift pipe.
  - In cycle N+1+RD_LAT the tag emerges and the matching rvalid pulses for one cycle, with rdata = mem_q that cycle.
  - Writes push valid=0 and produce no rvalid.
  - Returns are in issue order; no stall is possible.
  - c_rdata/x_rdata may hold mem_q continuously; they are only meaningful when rvalid=1.
- Starvation counter (4 bits, saturating at 15):
  - Increments when x_req=1 and x_gnt=0.
  - Clears when x_gnt=1 or x_req=0.
  - Worst-case aux wait = STARVE_LIM+1 cycles.
- Core read-after-aux-write to the same address, granted in consecutive cycles, returns the new data (memory write-first ordering; the arbiter adds no reordering).
- Reset mid-operation: in-flight reads are discarded; no rvalid is emitted after rst_n deasserts until a new read is granted.

Optional Feature:
- Macro: DMEM_ARB_WP_EN.
- When defined:
  - Adds localparam WP_BASE = 2**(ADDR_W-1).
  - A granted aux write with x_addr >= WP_BASE is handshaken normally (x_gnt=1), but mem_wren stays 0 and x_err pulses in cycle N+1.
  - Aux reads and all core accesses are unaffected.
- When undefined: x_err is tied to 0 and no address check exists.

Test Plan:
- Core read: mem[0x005]=0xDEADBEEF, c_req=1, c_we=0, c_addr=0x005 in cycle 0 -> c_gnt=1 cycle 0; mem_address=0x005, mem_wren=0 cycle 1; c_rvalid=1, c_rdata=0xDEADBEEF cycle 1+RD_LAT; x_rvalid stays 0.
- Conflict: c_req and x_req both 1 in cycle 0, c_req dropped in cycle 1 -> c_gnt cycle 0, x_gnt cycle 1; mem_address shows c_addr in cycle 1 and x_addr in cycle 2.
- Starvation (STARVE_LIM=4): c_req and x_req held high continuously -> c_gnt in cycles 0-3, x_gnt in cycle 4, c_gnt resumes cycle 5, starve_cnt=0 after cycle 4.
- Back-to-back mixed: core write 0x12345678 to 0x020 in cycle 0, core read 0x020 in cycle 1 -> mem_wren=1 only in cycle 1; c_rvalid with 0x12345678 in cycle 2+RD_LAT.
- Reset mid-read: grant a core read in cycle 0, assert rst_n=0 in cycle 1 -> all outputs 0; after release, no c_rvalid appears.
- DMEM_ARB_WP_EN (ADDR_W=10): aux write to 0x200 -> x_gnt=1, mem_wren=0, x_err=1 next cycle; aux write to 0x1FF -> mem_wren=1, x_err=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data memory: core has fixed priority,
// aux is promoted after STARVE_LIM denied cycles. Optional aux write protect: DMEM_ARB_WP_EN.
module dmem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              x_req,
  input  logic              x_we,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_wdata,
  output logic              x_gnt,
  output logic              x_rvalid,
  output logic [DATA_W-1:0] x_rdata,
  output logic              x_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam logic [3:0] STARVE_LIM_V = 4'(STARVE_LIM);

  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_wren_q, mem_wren_d;
  logic              x_err_q, x_err_d;
  logic [3:0]        starve_q, starve_d;
  // Tag pipe: stage k holds the read issued k+1 cycles ago; port bit 1 = aux.
  logic [RD_LAT:0]   tag_vld_q, tag_vld_d;
  logic [RD_LAT:0]   tag_port_q, tag_port_d;

  logic x_prio;
  logic wp_block;

  assign x_prio = x_req && (starve_q >= STARVE_LIM_V);
  assign c_gnt  = rst_n && c_req && !x_prio;
  assign x_gnt  = rst_n && x_req && (x_prio || !c_req);

`ifdef DMEM_ARB_WP_EN
  localparam logic [ADDR_W-1:0] WP_BASE = ADDR_W'(2 ** (ADDR_W - 1));
  assign wp_block = x_gnt && x_we && (x_addr >= WP_BASE);
`else
  assign wp_block = 1'b0;
`endif

  always_comb begin
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    mem_wren_d    = 1'b0;
    x_err_d       = wp_block;
    starve_d      = 4'd0;
    tag_vld_d     = {tag_vld_q[RD_LAT-1:0], 1'b0};
    tag_port_d    = {tag_port_q[RD_LAT-1:0], 1'b0};

    if (c_gnt) begin
      mem_address_d = c_addr;
      mem_data_d    = c_wdata;
      mem_wren_d    = c_we;
      tag_vld_d[0]  = !c_we;
    end else if (x_gnt) begin
      mem_address_d = x_addr;
      mem_data_d    = x_wdata;
      mem_wren_d    = x_we && !wp_block;
      tag_vld_d[0]  = !x_we;
      tag_port_d[0] = 1'b1;
    end

    if (x_req && !x_gnt && starve_q != 4'hF) begin
      starve_d = starve_q + 4'd1;
    end else if (x_req && !x_gnt) begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
      x_err_q       <= 1'b0;
      starve_q      <= 4'd0;
      tag_vld_q     <= '0;
      tag_port_q    <= '0;
    end else begin
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_wren_q    <= mem_wren_d;
      x_err_q       <= x_err_d;
      starve_q      <= starve_d;
      tag_vld_q     <= tag_vld_d;
      tag_port_q    <= tag_port_d;
    end
  end

  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign mem_wren    = mem_wren_q;
  assign x_err       = x_err_q;

  assign c_rvalid = tag_vld_q[RD_LAT] && !tag_port_q[RD_LAT];
  assign x_rvalid = tag_vld_q[RD_LAT] && tag_port_q[RD_LAT];
  assign c_rdata  = mem_q;
  assign x_rdata  = mem_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port synchronous memory attached.
module tb_dmem_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic c_req, c_we, x_req, x_we;
  logic [ADDR_W-1:0] c_addr, x_addr;
  logic [DATA_W-1:0] c_wdata, x_wdata;
  logic c_gnt, c_rvalid, x_gnt, x_rvalid, x_err;
  logic [DATA_W-1:0] c_rdata, x_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data, mem_q;
  logic mem_wren;
  logic preload;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_LIM(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
    .x_gnt(x_gnt), .x_rvalid(x_rvalid), .x_rdata(x_rdata), .x_err(x_err),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  // Memory model: registered read with RD_LAT stages, preloaded while 'preload' is high.
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] q_pipe [RD_LAT];
  always @(posedge clk) begin
    if (preload) begin
      mem[10'h005] <= 32'hDEADBEEF;
      mem[10'h011] <= 32'h11110011;
      mem[10'h033] <= 32'hA5A50033;
    end else if (mem_wren) begin
      mem[mem_address] <= mem_data;
    end
    q_pipe[0] <= mem[mem_address];
    for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign mem_q = q_pipe[RD_LAT-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    x_req = 0; x_we = 0; x_addr = '0; x_wdata = '0;
  endtask

  task automatic test_reset();
    step();
    c_req = 1; x_req = 1;
    #1;
    checks++; if (c_gnt !== 1'b0) begin failures++; $display("FAIL reset_c_gnt got=%b exp=0", c_gnt); end
    checks++; if (x_gnt !== 1'b0) begin failures++; $display("FAIL reset_x_gnt got=%b exp=0", x_gnt); end
    checks++; if (mem_wren !== 1'b0) begin failures++; $display("FAIL reset_mem_wren got=%b exp=0", mem_wren); end
    checks++; if (mem_address !== 10'h000) begin failures++; $display("FAIL reset_mem_address got=%h exp=000", mem_address); end
    checks++; if (c_rvalid !== 1'b0 || x_rvalid !== 1'b0 || x_err !== 1'b0) begin
      failures++; $display("FAIL reset_pulses got=%b%b%b exp=000", c_rvalid, x_rvalid, x_err); end
    step();
    idle_inputs();
    preload = 0; rst_n = 1;
    $display("txn reset released");
  endtask

  task automatic test_core_read();
    step();
    c_req = 1; c_we = 0; c_addr = 10'h005;
    #1;
    checks++; if (c_gnt !== 1'b1 || x_gnt !== 1'b0) begin failures++; $display("FAIL cr_gnt got=%b%b exp=10", c_gnt, x_gnt); end
    for (int k = 1; k <= RD_LAT + 2; k++) begin
      step();
      c_req = 0;
      #1;
      if (k == 1) begin
        checks++; if (mem_address !== 10'h005 || mem_wren !== 1'b0) begin
          failures++; $display("FAIL cr_issue got=%h/%b exp=005/0", mem_address, mem_wren); end
      end
      checks++;
      if (c_rvalid !== (k == 1 + RD_LAT) || x_rvalid !== 1'b0) begin
        failures++; $display("FAIL cr_rvalid_cyc%0d got=%b%b exp=%b0", k, c_rvalid, x_rvalid, k == 1 + RD_LAT); end
      if (k == 1 + RD_LAT) begin
        checks++; if (c_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL cr_rdata got=%h exp=deadbeef", c_rdata); end
      end
    end
    $display("txn core read 005");
  endtask

  task automatic test_conflict();
    step();
    c_req = 1; c_addr = 10'h011; x_req = 1; x_addr = 10'h033;
    #1;
    checks++; if (c_gnt !== 1'b1 || x_gnt !== 1'b0) begin failures++; $display("FAIL cf_gnt0 got=%b%b exp=10", c_gnt, x_gnt); end
    step();
    c_req = 0;
    #1;
    checks++; if (c_gnt !== 1'b0 || x_gnt !== 1'b1) begin failures++; $display("FAIL cf_gnt1 got=%b%b exp=01", c_gnt, x_gnt); end
    checks++; if (mem_address !== 10'h011) begin failures++; $display("FAIL cf_addr1 got=%h exp=011", mem_address); end
    step();
    x_req = 0;
    #1;
    checks++; if (mem_address !== 10'h033) begin failures++; $display("FAIL cf_addr2 got=%h exp=033", mem_address); end
    checks++; if (c_rvalid !== 1'b1 || c_rdata !== 32'h11110011) begin
      failures++; $display("FAIL cf_c_ret got=%b/%h exp=1/11110011", c_rvalid, c_rdata); end
    step();
    checks++; if (x_rvalid !== 1'b1 || c_rvalid !== 1'b0 || x_rdata !== 32'hA5A50033) begin
      failures++; $display("FAIL cf_x_ret got=%b%b/%h exp=10/a5a50033", x_rvalid, c_rvalid, x_rdata); end
    $display("txn conflict c=011 x=033");
  endtask

  task automatic test_starvation();
    step();
    c_req = 1; c_addr = 10'h040; x_req = 1; x_addr = 10'h041;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) step();
      #1;
      checks++;
      if (c_gnt !== (k != 4) || x_gnt !== (k == 4)) begin
        failures++; $display("FAIL starve_cyc%0d got=%b%b exp=%b%b", k, c_gnt, x_gnt, k != 4, k == 4); end
      if (k == 4) begin
        checks++; if (dut.starve_q !== 4'd4) begin failures++; $display("FAIL starve_cnt4 got=%0d exp=4", dut.starve_q); end
      end
      if (k == 5) begin
        checks++; if (dut.starve_q !== 4'd0) begin failures++; $display("FAIL starve_cnt5 got=%0d exp=0", dut.starve_q); end
      end
    end
    step();
    idle_inputs();
    repeat (RD_LAT + 2) step();
    $display("txn starvation c+x held 6 cycles");
  endtask

  task automatic test_back_to_back();
    step();
    c_req = 1; c_we = 1; c_addr = 10'h020; c_wdata = 32'h12345678;
    #1;
    checks++; if (c_gnt !== 1'b1) begin failures++; $display("FAIL b2b_w_gnt got=%b exp=1", c_gnt); end
    step();
    c_we = 0;
    #1;
    checks++; if (c_gnt !== 1'b1) begin failures++; $display("FAIL b2b_r_gnt got=%b exp=1", c_gnt); end
    checks++; if (mem_wren !== 1'b1 || mem_address !== 10'h020 || mem_data !== 32'h12345678) begin
      failures++; $display("FAIL b2b_wr_issue got=%b/%h/%h exp=1/020/12345678", mem_wren, mem_address, mem_data); end
    for (int k = 2; k <= 2 + RD_LAT; k++) begin
      step();
      c_req = 0;
      #1;
      if (k == 2) begin
        checks++; if (mem_wren !== 1'b0) begin failures++; $display("FAIL b2b_wren_drop got=%b exp=0", mem_wren); end
      end
      checks++; if (c_rvalid !== (k == 2 + RD_LAT)) begin
        failures++; $display("FAIL b2b_rvalid_cyc%0d got=%b exp=%b", k, c_rvalid, k == 2 + RD_LAT); end
    end
    checks++; if (c_rdata !== 32'h12345678) begin failures++; $display("FAIL b2b_rdata got=%h exp=12345678", c_rdata); end
    // Aux write followed immediately by a core read of the same word.
    step();
    x_req = 1; x_we = 1; x_addr = 10'h0AB; x_wdata = 32'hCAFE0001;
    #1;
    checks++; if (x_gnt !== 1'b1) begin failures++; $display("FAIL raw_x_gnt got=%b exp=1", x_gnt); end
    step();
    x_req = 0; x_we = 0; c_req = 1; c_addr = 10'h0AB;
    #1;
    checks++; if (c_gnt !== 1'b1 || mem_wren !== 1'b1) begin failures++; $display("FAIL raw_issue got=%b%b exp=11", c_gnt, mem_wren); end
    repeat (1 + RD_LAT) begin
      step();
      c_req = 0;
    end
    #1;
    checks++; if (c_rvalid !== 1'b1 || c_rdata !== 32'hCAFE0001) begin
      failures++; $display("FAIL raw_ret got=%b/%h exp=1/cafe0001", c_rvalid, c_rdata); end
    step();
    $display("txn back-to-back write/read 020 and aux-write/core-read 0ab");
  endtask

  task automatic test_write_protect();
    step();
    x_req = 1; x_we = 1; x_addr = 10'h200; x_wdata = 32'h0000BAD0;
    #1;
    checks++; if (x_gnt !== 1'b1) begin failures++; $display("FAIL wp_hi_gnt got=%b exp=1", x_gnt); end
    step();
    x_addr = 10'h1FF; x_wdata = 32'h0000600D;
    #1;
`ifdef DMEM_ARB_WP_EN
    checks++; if (mem_wren !== 1'b0 || x_err !== 1'b1) begin
      failures++; $display("FAIL wp_hi_block got=%b/%b exp=wren0/err1", mem_wren, x_err); end
`else
    checks++; if (mem_wren !== 1'b1 || x_err !== 1'b0) begin
      failures++; $display("FAIL wp_hi_pass got=%b/%b exp=wren1/err0", mem_wren, x_err); end
`endif
    step();
    x_req = 0; x_we = 0;
    #1;
    checks++; if (mem_wren !== 1'b1 || x_err !== 1'b0 || mem_address !== 10'h1FF) begin
      failures++; $display("FAIL wp_lo_pass got=%b/%b/%h exp=1/0/1ff", mem_wren, x_err, mem_address); end
    step();
    $display("txn aux writes 200 and 1ff");
  endtask

  task automatic test_reset_mid();
    step();
    c_req = 1; c_we = 0; c_addr = 10'h005; c_wdata = 32'h00000055;
    #1;
    checks++; if (c_gnt !== 1'b1) begin failures++; $display("FAIL rm_gnt got=%b exp=1", c_gnt); end
    step();
    rst_n = 0; x_req = 1;
    #1;
    checks++;
    if (c_gnt !== 0 || x_gnt !== 0 || mem_wren !== 0 || mem_address !== '0 || mem_data !== '0 ||
        c_rvalid !== 0 || x_rvalid !== 0 || x_err !== 0) begin
      failures++; $display("FAIL rm_outputs got=gnt%b%b wren%b addr%h data%h rv%b%b err%b exp=all0",
                           c_gnt, x_gnt, mem_wren, mem_address, mem_data, c_rvalid, x_rvalid, x_err);
    end
    step();
    idle_inputs();
    rst_n = 1;
    for (int k = 0; k < RD_LAT + 3; k++) begin
      #1;
      checks++; if (c_rvalid !== 1'b0 || x_rvalid !== 1'b0) begin
        failures++; $display("FAIL rm_no_rvalid_cyc%0d got=%b%b exp=00", k, c_rvalid, x_rvalid); end
      step();
    end
    $display("txn reset during read");
  endtask

  initial begin
    rst_n = 0; preload = 1;
    idle_inputs();
    test_reset();
    test_core_read();
    test_conflict();
    test_starvation();
    test_back_to_back();
    test_write_protect();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
